// File: rtl/store_serializer_pkg.sv
// Shared definitions for the store serializer: opcode macros live with the other instruction encodings.
// Package constants mirror them for code that imports the package.
`ifndef STORE_OPCODES_DEFINED
`define STORE_OPCODES_DEFINED
`define MOVAR8 8'h38
`define MOVAR4 8'h34
`define MOVAR1 8'h31
`endif

package store_serializer_pkg;
  localparam logic [7:0] OPC_MOVAR8 = `MOVAR8;
  localparam logic [7:0] OPC_MOVAR4 = `MOVAR4;
  localparam logic [7:0] OPC_MOVAR1 = `MOVAR1;
endpackage

// File: rtl/store_byte_mux.sv
// Combinational 64->8 byte-lane select; lane 0 is the least significant byte.
module store_byte_mux (
  input  logic [63:0] data,
  input  logic [2:0]  sel,
  output logic [7:0]  lane
);
  assign lane = data[{sel, 3'b000} +: 8];
endmodule

// File: rtl/store_serializer.sv
// Serializes one 8/4/1-byte register store onto a byte-wide memory write port, little-endian,
// and reports completion or error to the sequencer with a one-cycle done pulse.
module store_serializer
  import store_serializer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_opc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FIN = 2'd2} state_e;

  localparam logic [3:0] LEN8    = 4'd8;
  localparam logic [3:0] LEN4    = 4'd4;
  localparam logic [3:0] LEN1    = 4'd1;
  localparam logic [3:0] LEN_BAD = 4'd0;
  localparam int         STALL_W = 16;

  // Zero length marks a non-store opcode.
  function automatic logic [3:0] len_of(input logic [7:0] opc);
    case (opc)
      OPC_MOVAR8: len_of = LEN8;
      OPC_MOVAR4: len_of = LEN4;
      OPC_MOVAR1: len_of = LEN1;
      default:    len_of = LEN_BAD;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [63:0]         data_q, data_d;
  logic [3:0]          len_q, len_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                err_q, err_d;
  logic [7:0]          lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr;
          data_d  = req_data;
          len_d   = len_of(req_opc);
          cnt_d   = '0;
          stall_d = '0;
          if (len_d != LEN_BAD) begin
            state_d = WRITE;
            err_d   = 1'b0;
          end else begin
            state_d = FIN;
            err_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          cnt_d   = cnt_q + 4'd1;
          stall_d = '0;
          if (cnt_q == len_q - 4'd1) begin
            state_d = FIN;
            err_d   = 1'b0;
          end
        end else begin
          // Abort once the run of unacknowledged cycles reaches TIMEOUT.
          stall_d = stall_q + 1'b1;
          if ((TIMEOUT != 0) && (stall_d == STALL_W'(TIMEOUT))) begin
            state_d = FIN;
            err_d   = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  store_byte_mux u_mux (
    .data (data_q),
    .sel  (cnt_q[2:0]),
    .lane (lane)
  );

  // Outputs decode registered state only; address/data read as zero outside WRITE.
  assign req_ready = (state_q == IDLE);
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_we ? (base_q + ADDR_W'(cnt_q)) : '0;
  assign mem_wdata = mem_we ? lane : 8'h00;
  assign done      = (state_q == FIN);
  assign err       = done & err_q;
endmodule

// File: tb/tb_store_serializer.sv
// Scoreboard bench for store_serializer: stimulus pushes expected beats/completions,
// a negedge monitor compares whatever the DUT presents.
module tb_store_serializer;
  import store_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opc = 8'h00;
  logic [15:0] req_addr = 16'h0000;
  logic [63:0] req_data = 64'h0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b1;
  logic        done;
  logic        err;

  store_serializer #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    bit          acked;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_beats(input int n, input logic [15:0] a, input logic [63:0] d,
                            input int acc, input int sb, input int sn, input bit acked);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.is_done = 1'b0;
      e.acked   = acked;
      e.addr    = a + 16'(k);
      e.data    = d[8*k +: 8];
      e.err     = 1'b0;
      e.cyc     = acc + 1 + k + ((k >= sb) ? sn : 0);
      q.push_back(e);
    end
  endtask

  task automatic push_done(input int c, input bit e_err);
    exp_t e;
    e.is_done = 1'b1;
    e.acked   = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    e.err     = e_err;
    e.cyc     = c;
    q.push_back(e);
  endtask

  // Monitor: every write-strobe cycle must show the head beat; acked beats pop with their cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (q.size() == 0 || q[0].is_done) begin
        checks++;
        $display("FAIL stray_beat: got addr %0h data %0h, required no write (cycle %0d)",
                 mem_addr, mem_wdata, cyc);
      end else begin
        chk("beat_addr", 64'(mem_addr), 64'(q[0].addr));
        chk("beat_data", 64'(mem_wdata), 64'(q[0].data));
        if (mem_ack) begin
          chk("beat_acked", 64'(1), 64'(q[0].acked));
          chk("beat_cycle", 64'(cyc), 64'(q[0].cyc));
          void'(q.pop_front());
        end
      end
    end
    if (done === 1'b1) begin
      while (q.size() > 0 && !q[0].is_done && !q[0].acked) void'(q.pop_front());
      if (q.size() == 0 || !q[0].is_done) begin
        checks++;
        $display("FAIL stray_done: got done err=%0b, required no done (cycle %0d)", err, cyc);
      end else begin
        chk("done_err", 64'(err), 64'(q[0].err));
        chk("done_cycle", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [7:0] o, input logic [15:0] a, input logic [63:0] d,
                       output int acc);
    bit got;
    got = 1'b0;
    acc = -1000;
    req_opc = o;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        got = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    req_data = '1;
    req_addr = 16'h5A5A;
    if (!got) begin
      checks++;
      $display("FAIL accept_timeout: got no acceptance, required acceptance within 100 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending events, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    logic [63:0] d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    @(posedge clk);
    #1;

    // MOVAR1: single beat 0xAB at 0x0010, done next cycle
    issue(OPC_MOVAR1, 16'h0010, 64'h1234_5678_9ABC_DEAB, acc);
    push_beats(1, 16'h0010, 64'h0000_0000_0000_00AB, acc, 99, 0, 1'b1);
    push_done(acc + 2, 1'b0);
    drain();

    // MOVAR4: four low bytes only
    issue(OPC_MOVAR4, 16'h0100, 64'hFFFF_FFFF_1122_3344, acc);
    push_beats(4, 16'h0100, 64'h0000_0000_1122_3344, acc, 99, 0, 1'b1);
    push_done(acc + 5, 1'b0);
    drain();

    // MOVAR8 wrapping past 0xFFFF
    issue(OPC_MOVAR8, 16'hFFFE, 64'h0807_0605_0403_0201, acc);
    push_beats(8, 16'hFFFE, 64'h0807_0605_0403_0201, acc, 99, 0, 1'b1);
    push_done(acc + 9, 1'b0);
    drain();

    // MOVAR4 with three stalled cycles on beat 1
    d = 64'hDEAD_BEEF_CAFE_F00D;
    issue(OPC_MOVAR4, 16'h0200, d, acc);
    push_beats(4, 16'h0200, d, acc, 1, 3, 1'b1);
    push_done(acc + 8, 1'b0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ack = 1'b1;
    drain();

    // Ack stuck low: abort after TIMEOUT=4 stall cycles, beat 0 never completes
    mem_ack = 1'b0;
    issue(OPC_MOVAR8, 16'h0300, 64'h1111_2222_3333_4477, acc);
    push_beats(1, 16'h0300, 64'h0000_0000_0000_0077, acc, 99, 0, 1'b0);
    push_done(acc + 5, 1'b1);
    drain();
    mem_ack = 1'b1;

    // Non-store opcode: error completion with no writes
    issue(8'h81, 16'h0400, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    push_done(acc + 1, 1'b1);
    drain();

    // Request held while busy is accepted only back in IDLE
    issue(OPC_MOVAR4, 16'h0500, 64'h0000_0000_A1B2_C3D4, acc);
    push_beats(4, 16'h0500, 64'h0000_0000_A1B2_C3D4, acc, 99, 0, 1'b1);
    push_done(acc + 5, 1'b0);
    issue(OPC_MOVAR1, 16'h0600, 64'h0000_0000_0000_0099, acc2);
    chk("held_accept_cycle", 64'(acc2), 64'(acc + 6));
    push_beats(1, 16'h0600, 64'h0000_0000_0000_0099, acc2, 99, 0, 1'b1);
    push_done(acc2 + 2, 1'b0);
    drain();

    // Reset during beat 2 of a MOVAR8: beats 0..2 land, then silence
    issue(OPC_MOVAR8, 16'h0700, 64'h8877_6655_4433_2211, acc);
    push_beats(3, 16'h0700, 64'h8877_6655_4433_2211, acc, 99, 0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_we", 64'(mem_we), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(req_ready), 64'(1));
    chk("midrst_done2", 64'(done), 64'(0));
    chk("midrst_queue", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
    issue(OPC_MOVAR1, 16'h0800, 64'h0000_0000_0000_005C, acc);
    push_beats(1, 16'h0800, 64'h0000_0000_0000_005C, acc, 99, 0, 1'b1);
    push_done(acc + 2, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
